imem_stream_loader: RTL and testbench

Parametrised instruction memory for the pipelined core with a synchronous (block-RAM) fetch port, a direct word-write port, and a byte-stream boot loader that assembles little-endian bytes into words under a valid/ready handshake. It sits between the fetch stage and the external program-load path (UART/debug). It holds off fetch validity while a load is in progress and reports completion.

---
 rtl/imem_pkg.sv | 13 +
 rtl/imem_bram.sv | 33 +++
 rtl/imem_stream_loader.sv | 162 ++++++++++++++++
 tb/tb_imem_stream_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory and its stream loader.
package imem_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_LOAD = 2'd1,
        IMEM_DONE = 2'd2
    } imem_state_t;

    localparam int unsigned BYTES_PER_WORD     = 4;
    localparam int unsigned IMEM_DEFAULT_DEPTH = 2048;

endpackage

// File: rtl/imem_bram.sv
// Simple dual-port read-first block RAM: one write port, one registered read port.
module imem_bram
    import imem_pkg::*;
#(
    parameter int unsigned W     = 8 * BYTES_PER_WORD,
    parameter int unsigned DEPTH = IMEM_DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic          i_re,
    input  logic          i_rclr,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);

    (* ram_style = "block" *) logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read register samples the pre-write contents, giving read-first behaviour.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         o_rdata <= '0;
        else if (i_rclr) o_rdata <= '0;
        else if (i_re)   o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/imem_stream_loader.sv
// Instruction memory with fetch port, direct write port and little-endian byte-stream loader.
// Define IMEM_LOAD_CSUM_EN to add the load_csum output (sum of loader-written words).
module imem_stream_loader
    import imem_pkg::*;
#(
    parameter int unsigned W     = 8 * BYTES_PER_WORD,
    parameter int unsigned DEPTH = IMEM_DEFAULT_DEPTH,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [W-1:0]  pc,
    input  logic          fetch_en,
    output logic [W-1:0]  inst_data,
    output logic          inst_valid,
    output logic          fetch_oor,
    input  logic          is_write,
    input  logic [W-1:0]  im_addr,
    input  logic [W-1:0]  im_inst,
    input  logic          load_start,
    input  logic [AW:0]   load_len,
    input  logic          load_byte_valid,
    input  logic [7:0]    load_byte,
    output logic          load_byte_ready,
    output logic          loading,
    output logic          load_done
`ifdef IMEM_LOAD_CSUM_EN
    ,
    output logic [W-1:0]  load_csum
`endif
);

    localparam int unsigned BPW = W / 8;
    localparam int unsigned BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int unsigned IW  = W - 2;

    imem_state_t    r_state;
    logic [AW-1:0]  r_word_ptr;
    logic [BCW-1:0] r_byte_cnt;
    logic [AW:0]    r_words_left;
    logic [W-1:0]   r_asm;

    logic           w_in_load;
    logic           w_byte_xfer;
    logic           w_word_last_byte;
    logic [W-1:0]   w_word;
    logic [IW-1:0]  w_fetch_idx;
    logic           w_fetch_oor;
    logic           w_fetch_go;
    logic [IW-1:0]  w_wr_idx;
    logic           w_dir_we;
    logic           w_we;
    logic [AW-1:0]  w_waddr;
    logic [W-1:0]   w_wdata;
    logic           w_unused;

    assign w_in_load        = (r_state == IMEM_LOAD);
    assign w_byte_xfer      = load_byte_valid && load_byte_ready;
    assign w_word_last_byte = w_byte_xfer && (r_byte_cnt == BCW'(BPW - 1));

    // Completed word: bytes gathered so far plus the byte arriving this cycle.
    always_comb begin
        w_word = r_asm;
        w_word[8*r_byte_cnt +: 8] = load_byte;
    end

    assign w_fetch_idx = pc[W-1:2];
    assign w_fetch_oor = (w_fetch_idx >= IW'(DEPTH));
    assign w_fetch_go  = fetch_en && !w_in_load;

    // The loader owns the write port during LOAD; otherwise direct writes in range.
    assign w_wr_idx = im_addr[W-1:2];
    assign w_dir_we = is_write && !w_in_load && (w_wr_idx < IW'(DEPTH));
    assign w_we     = w_in_load ? w_word_last_byte : w_dir_we;
    assign w_waddr  = w_in_load ? r_word_ptr : w_wr_idx[AW-1:0];
    assign w_wdata  = w_in_load ? w_word : im_inst;

    assign w_unused = &{1'b0, pc[1:0], im_addr[1:0]};

    imem_bram #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_bram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_re    (w_fetch_go && !w_fetch_oor),
        .i_rclr  (w_fetch_go && w_fetch_oor),
        .i_raddr (w_fetch_idx[AW-1:0]),
        .o_rdata (inst_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IMEM_IDLE;
            r_word_ptr      <= '0;
            r_byte_cnt      <= '0;
            r_words_left    <= '0;
            r_asm           <= '0;
            load_byte_ready <= 1'b0;
            loading         <= 1'b0;
            load_done       <= 1'b0;
            inst_valid      <= 1'b0;
            fetch_oor       <= 1'b0;
        end else begin
            inst_valid <= w_fetch_go;
            fetch_oor  <= w_fetch_go && w_fetch_oor;
            load_done  <= 1'b0;
            case (r_state)
                IMEM_IDLE: begin
                    if (load_start) begin
                        r_word_ptr   <= '0;
                        r_byte_cnt   <= '0;
                        r_words_left <= load_len;
                        if (load_len != '0) begin
                            r_state         <= IMEM_LOAD;
                            load_byte_ready <= 1'b1;
                            loading         <= 1'b1;
                        end else begin
                            r_state   <= IMEM_DONE;
                            load_done <= 1'b1;
                        end
                    end
                end
                IMEM_LOAD: begin
                    if (w_byte_xfer) begin
                        r_asm <= w_word;
                        if (w_word_last_byte) begin
                            r_byte_cnt   <= '0;
                            r_word_ptr   <= (r_word_ptr == AW'(DEPTH - 1)) ? r_word_ptr
                                                                           : r_word_ptr + AW'(1);
                            r_words_left <= r_words_left - (AW+1)'(1);
                            if (r_words_left == (AW+1)'(1)) begin
                                r_state         <= IMEM_DONE;
                                load_byte_ready <= 1'b0;
                                loading         <= 1'b0;
                                load_done       <= 1'b1;
                            end
                        end else begin
                            r_byte_cnt <= r_byte_cnt + BCW'(1);
                        end
                    end
                end
                IMEM_DONE: r_state <= IMEM_IDLE;
                default:   r_state <= IMEM_IDLE;
            endcase
        end
    end

`ifdef IMEM_LOAD_CSUM_EN
    // Running sum of loader-written words; held once the load completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                     load_csum <= '0;
        else if (r_state == IMEM_IDLE && load_start) load_csum <= '0;
        else if (w_in_load && w_word_last_byte)      load_csum <= load_csum + w_word;
    end
`endif

endmodule

// File: tb/tb_imem_stream_loader.sv
// Randomized self-checking bench for imem_stream_loader against an array-based memory model.
module tb_imem_stream_loader;

    localparam int unsigned W     = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  pc;
    logic          fetch_en;
    logic [W-1:0]  inst_data;
    logic          inst_valid;
    logic          fetch_oor;
    logic          is_write;
    logic [W-1:0]  im_addr;
    logic [W-1:0]  im_inst;
    logic          load_start;
    logic [AW:0]   load_len;
    logic          load_byte_valid;
    logic [7:0]    load_byte;
    logic          load_byte_ready;
    logic          loading;
    logic          load_done;
`ifdef IMEM_LOAD_CSUM_EN
    logic [W-1:0]  load_csum;
`endif

    imem_stream_loader #(.W(W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk             (clk),
        .rst             (rst),
        .pc              (pc),
        .fetch_en        (fetch_en),
        .inst_data       (inst_data),
        .inst_valid      (inst_valid),
        .fetch_oor       (fetch_oor),
        .is_write        (is_write),
        .im_addr         (im_addr),
        .im_inst         (im_inst),
        .load_start      (load_start),
        .load_len        (load_len),
        .load_byte_valid (load_byte_valid),
        .load_byte       (load_byte),
        .load_byte_ready (load_byte_ready),
        .loading         (loading),
        .load_done       (load_done)
`ifdef IMEM_LOAD_CSUM_EN
        ,
        .load_csum       (load_csum)
`endif
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem_m [DEPTH];
    int unsigned  n_chk  = 0;
    int unsigned  n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] model_read(input logic [W-1:0] a);
        if ((a >> 2) >= DEPTH) return '0;
        return mem_m[a >> 2];
    endfunction

    task automatic direct_write(input logic [W-1:0] a, input logic [W-1:0] d);
        is_write = 1'b1; im_addr = a; im_inst = d;
        step();
        is_write = 1'b0;
        if ((a >> 2) < DEPTH) mem_m[a >> 2] = d;
    endtask

    // Back-to-back fetches; each result is checked one cycle after its request.
    task automatic fetch_burst(input string tag, input logic [W-1:0] addrs[$]);
        logic [W-1:0] exp_d;
        logic         exp_o;
        foreach (addrs[i]) begin
            pc       = addrs[i];
            fetch_en = 1'b1;
            exp_d    = model_read(addrs[i]);
            exp_o    = ((addrs[i] >> 2) >= DEPTH);
            step();
            chk({tag, "_valid"}, 32'(inst_valid), 32'd1);
            chk({tag, "_data"},  inst_data, exp_d);
            chk({tag, "_oor"},   32'(fetch_oor), 32'(exp_o));
        end
        fetch_en = 1'b0;
    endtask

    // Streams the words as LE bytes; gapped alternates idle cycles, poke uses them
    // for a write, a fetch and a repeated load_start that the loader must ignore.
    task automatic run_load(input logic [W-1:0] words[$], input bit gapped, input bit poke);
        logic [7:0]   bytes_q[$];
        logic [W-1:0] sum;
        logic [W-1:0] w;
        bit           gap_now;
        sum = '0;
        foreach (words[i]) begin
            w = words[i];
            for (int k = 0; k < 4; k++) bytes_q.push_back(w[8*k +: 8]);
        end
        load_start = 1'b1;
        load_len   = (AW+1)'(words.size());
        step();
        load_start = 1'b0;
        chk("loading_rise", 32'(loading), 32'd1);
        chk("ready_rise",   32'(load_byte_ready), 32'd1);
        gap_now = 1'b0;
        while (bytes_q.size() != 0) begin
            if (gapped && gap_now) begin
                if (poke) begin
                    is_write = 1'b1; im_addr = 32'h8; im_inst = 32'hDEADBEEF;
                    fetch_en = 1'b1; pc = 32'h0;
                    load_start = 1'b1; load_len = (AW+1)'(1);
                end
                step();
                is_write = 1'b0; fetch_en = 1'b0; load_start = 1'b0;
                if (poke) chk("fetch_in_load_valid", 32'(inst_valid), 32'd0);
            end else begin
                load_byte_valid = 1'b1;
                load_byte       = bytes_q.pop_front();
                step();
                load_byte_valid = 1'b0;
                if (bytes_q.size() != 0) begin
                    chk("loading_mid", 32'(loading), 32'd1);
                    chk("done_early",  32'(load_done), 32'd0);
                end
            end
            gap_now = !gap_now;
        end
        chk("done_pulse",   32'(load_done), 32'd1);
        chk("loading_fall", 32'(loading), 32'd0);
        chk("ready_fall",   32'(load_byte_ready), 32'd0);
        foreach (words[i]) begin
            mem_m[(i < DEPTH) ? i : DEPTH - 1] = words[i];
            sum += words[i];
        end
        step();
        chk("done_single", 32'(load_done), 32'd0);
        chk("loading_idle", 32'(loading), 32'd0);
`ifdef IMEM_LOAD_CSUM_EN
        chk("csum", load_csum, sum);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] wq[$];
        logic [W-1:0] aq[$];
        logic [W-1:0] old;
        rst = 1'b1; pc = '0; fetch_en = 1'b0; is_write = 1'b0; im_addr = '0; im_inst = '0;
        load_start = 1'b0; load_len = '0; load_byte_valid = 1'b0; load_byte = '0;
        step(); step();
        chk("rst_inst_data", inst_data, 32'd0);
        chk("rst_inst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fetch_oor", 32'(fetch_oor), 32'd0);
        chk("rst_ready", 32'(load_byte_ready), 32'd0);
        chk("rst_loading", 32'(loading), 32'd0);
        chk("rst_done", 32'(load_done), 32'd0);
        rst = 1'b0;
        step();

        for (int i = 0; i < DEPTH; i++) direct_write(32'(4 * i), $urandom);

        // Directed program load of two words.
        wq = {}; wq.push_back(32'h00000013); wq.push_back(32'h00100093);
        run_load(wq, 1'b0, 1'b0);
        aq = {}; aq.push_back(32'h0); aq.push_back(32'h4);
        fetch_burst("fetch_prog", aq);

        // Gapped load with ignored write/fetch/load_start pokes.
        wq = {}; wq.push_back($urandom); wq.push_back($urandom);
        run_load(wq, 1'b1, 1'b1);
        aq = {}; aq.push_back(32'h0); aq.push_back(32'h4); aq.push_back(32'h8);
        fetch_burst("fetch_gapped", aq);

        // Direct write in IDLE with a simultaneous fetch of the same word.
        old = mem_m[2];
        is_write = 1'b1; im_addr = 32'h8; im_inst = 32'hDEADBEEF;
        fetch_en = 1'b1; pc = 32'h8;
        step();
        is_write = 1'b0; fetch_en = 1'b0;
        mem_m[2] = 32'hDEADBEEF;
        chk("rfw_old_data", inst_data, old);
        aq = {}; aq.push_back(32'h8);
        fetch_burst("fetch_after_write", aq);

        // Out-of-range write must not alias; out-of-range fetch returns 0.
        direct_write(32'(4 * (DEPTH + 8)), 32'h12345678);
        aq = {}; aq.push_back(32'(4 * DEPTH)); aq.push_back(32'h20); aq.push_back(32'hFFFF_FFFC);
        fetch_burst("fetch_oor", aq);

        // Zero-length load goes straight to DONE for one cycle.
        load_start = 1'b1; load_len = '0;
        step();
        load_start = 1'b0;
        chk("len0_done", 32'(load_done), 32'd1);
        chk("len0_loading", 32'(loading), 32'd0);
        step();
        chk("len0_done_single", 32'(load_done), 32'd0);

        // Randomized traffic: direct writes, then random fetches.
        for (int i = 0; i < 12; i++) direct_write($urandom_range(0, 4 * DEPTH + 63), $urandom);
        aq = {};
        for (int i = 0; i < 24; i++) aq.push_back($urandom_range(0, 4 * DEPTH + 63));
        fetch_burst("fetch_rand", aq);

        // Random-length load, then an overlong load saturating at the last word.
        wq = {};
        for (int i = 0, n = $urandom_range(3, 9); i < n; i++) wq.push_back($urandom);
        run_load(wq, $urandom_range(0, 1) == 1, 1'b0);
        wq = {};
        for (int i = 0; i < DEPTH + 2; i++) wq.push_back($urandom);
        run_load(wq, 1'b0, 1'b0);
        aq = {}; aq.push_back(32'h0); aq.push_back(32'(4 * (DEPTH - 2))); aq.push_back(32'(4 * (DEPTH - 1)));
        fetch_burst("fetch_overlong", aq);

        // Reset after six bytes of a two-word load: word0 kept, partial word1 dropped.
        wq = {}; wq.push_back($urandom); wq.push_back($urandom);
        load_start = 1'b1; load_len = (AW+1)'(2);
        step();
        load_start = 1'b0;
        for (int b = 0; b < 6; b++) begin
            old = wq[b / 4];
            load_byte_valid = 1'b1; load_byte = old[8*(b%4) +: 8];
            step();
        end
        load_byte_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("midrst_loading", 32'(loading), 32'd0);
        chk("midrst_ready", 32'(load_byte_ready), 32'd0);
        chk("midrst_done", 32'(load_done), 32'd0);
        step();
        rst = 1'b0;
        mem_m[0] = wq[0];
        step();
        aq = {}; aq.push_back(32'h0); aq.push_back(32'h4);
        fetch_burst("fetch_midrst", aq);
        wq = {}; wq.push_back($urandom);
        run_load(wq, 1'b0, 1'b0);
        aq = {}; aq.push_back(32'h0); aq.push_back(32'h4);
        fetch_burst("fetch_reload", aq);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
